spi_pattern_gen: RTL and testbench
==================================

// Module: spi_pattern_gen
// PURPOSE
//  Writer-side counterpart of the FIFO pattern checker: pushes frames of the ASCII sequence
//  FIRST_CHAR..FIRST_CHAR+PATTERN_LEN-1 (default '1'..'9', 8'h31..8'h39) into a show-ahead FIFO.
//  Sits in front of the SPI/JTAG loopback path so that the far-end checker sees a known stream.
//  Supports a bounded or continuous frame count, an inter-frame gap and full-FIFO backpressure.
// PARAMETERS
//  DATA         8      byte width of wdata
//  FIFO_DEPTH   16     depth of the target FIFO; sets the usedw width $clog2(FIFO_DEPTH)
//  PATTERN_LEN  9      bytes per frame, 1..255
//  FIRST_CHAR   8'h31  value of byte 0 of each frame
//  GAP_CYCLES   2      idle cycles between frames, 0..255
// PORTS
//  clk     in   1                    system clock; all logic on posedge
//  rst     in   1                    asynchronous, active-low reset
//  start   in   1                    1-cycle pulse; latches frames and starts generation
//  stop    in   1                    1-cycle pulse; finishes the current frame, then stops
//  frames  in   8                    frame count latched at start; 0 = continuous
//  wdata   out  DATA                 FIFO write data
//  wr      out  1                    FIFO write strobe; one byte is written per cycle with wr=1
//  full    in   1                    FIFO full flag
//  usedw   in   $clog2(FIFO_DEPTH)   FIFO fill level; status only, not used for control
//  busy    out  1                    high from the cycle after start until DONE
//  done    out  1                    1-cycle pulse when generation ends
//  frm_cnt out  8                    completed frames, wraps at 255
// BEHAVIOUR
//  Reset (rst=0, asynchronous): wr=0, wdata=0, busy=0, done=0, frm_cnt=0, state=IDLE, idx=0.
//  Reset asserted mid-frame aborts immediately; there is no partial-frame flush.
//  FSM states: IDLE, WRITE, GAP, DONE.
//   IDLE:  on start go to WRITE, latch frames into frm_tgt, clear frm_cnt and idx.
//   WRITE: wr = !full (combinational); wdata = FIRST_CHAR + idx (registered).
//          On each cycle with wr=1, idx increments.
//          When the write at idx=PATTERN_LEN-1 lands: idx <= 0 and frm_cnt++.
//          After that write: if stop is pending, or frm_tgt != 0 and frm_cnt+1 == frm_tgt,
//          go to DONE; else go to GAP, or back to WRITE when GAP_CYCLES=0.
//   GAP:   wr=0 for exactly GAP_CYCLES cycles, then WRITE.
//   DONE:  done=1 for one cycle, busy=0, then IDLE.
//  Backpressure: full=1 holds wr=0, and idx and wdata stay stable; resumes the cycle full drops.
//  Throughput: 1 byte/clk while full=0.
//   First write happens the cycle after start (latency 1).
//  stop: sticky until consumed; ignored in IDLE. Frames are never truncated.
//   stop in GAP goes to DONE at the end of the gap.
//  start while busy is ignored. start and stop in the same cycle in IDLE: start wins, stop is dropped.
//  Arithmetic: wdata = FIRST_CHAR + idx modulo 2^DATA; frm_cnt wraps modulo 256.
// CONFIGURATION
//  SPI_PATTERN_ERR_INJ_EN defined:
//   - adds input err_inj (1 bit, sticky request).
//   - The next byte written with idx == PATTERN_LEN/2 has bit 0 inverted; the request then clears.
//   - Lets the bench force the checker's check flag.
//  Undefined: no err_inj port; the stream is always clean.
// STRUCTURE
//  spi_pkg: typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} pgen_state_t;
//   localparams PGEN_FIRST_CHAR = 8'h31 and PGEN_LEN = 9, shared with the checker.
//  No sub-module: single flat FSM with counters idx, gap_cnt, frm_cnt and frm_tgt.
// TESTING
//  1. frames=1, full=0, start -> wr high 9 consecutive cycles, bytes 31..39, done pulse, frm_cnt=1.
//  2. frames=3, GAP_CYCLES=2 -> 27 writes, exactly 2 idle cycles between frames, frm_cnt=3.
//  3. full=1 for 4 cycles at idx=4 -> no write while full, 8'h35 held, then 35..39 in order.
//  4. frames=0, stop pulse at idx=2 of frame 2 -> frame 2 completes to 8'h39, done; 18 bytes total.
//  5. rst=0 asynchronously mid-frame -> wr/busy/done/frm_cnt are 0 immediately; next start restarts at 8'h31.
//  6. SPI_PATTERN_ERR_INJ_EN, err_inj=1 -> 5th byte is 8'h34; the downstream checker raises check=1.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Types and constants shared by the SPI/JTAG loopback pattern generator and
// the far-end FIFO pattern checker.
//   pgen_state_t     generator FSM state encoding
//   PGEN_FIRST_CHAR  value of byte 0 of every frame ('1')
//   PGEN_LEN         bytes per frame ('1'..'9')
// ---------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } pgen_state_t;

   localparam logic [7:0] PGEN_FIRST_CHAR = 8'h31;
   localparam int         PGEN_LEN        = 9;

endpackage : spi_pkg

// File: rtl/spi_pattern_gen.sv
// ---------------------------------------------------------------------------
// spi_pattern_gen
// Writer-side pattern source: pushes frames of FIRST_CHAR..FIRST_CHAR+
// PATTERN_LEN-1 into a show-ahead FIFO so the far-end checker sees a known
// stream. Bounded or continuous frame count, inter-frame gap, and full-FIFO
// backpressure.
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst      in   asynchronous, active-low reset
//   start    in   1-cycle pulse, latches frames and starts generation (IDLE only)
//   stop     in   1-cycle pulse, finish the current frame then stop (sticky)
//   frames   in   frame count latched at start, 0 = continuous
//   wdata    out  FIFO write data (registered)
//   wr       out  FIFO write strobe, one byte per cycle with wr=1
//   full     in   FIFO full flag
//   usedw    in   FIFO fill level, status only
//   busy     out  high from the cycle after start until DONE
//   done     out  1-cycle pulse when generation ends
//   frm_cnt  out  completed frames, wraps at 255
//   err_inj  in   (SPI_PATTERN_ERR_INJ_EN only) sticky request to corrupt
//                 bit 0 of the next byte written at idx == PATTERN_LEN/2
//
// Build option: define SPI_PATTERN_ERR_INJ_EN to add the err_inj port.
// Without it the stream is always clean.
// ---------------------------------------------------------------------------
module spi_pattern_gen
   import spi_pkg::*;
#(
   parameter int               DATA        = 8,
   parameter int               FIFO_DEPTH  = 16,
   parameter int               PATTERN_LEN = PGEN_LEN,
   parameter logic [7:0]       FIRST_CHAR  = PGEN_FIRST_CHAR,
   parameter int               GAP_CYCLES  = 2,
   localparam int              USEDW_W     = $clog2(FIFO_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [7:0]         frames,
   output logic [DATA-1:0]    wdata,
   output logic               wr,
   input  logic               full,
   input  logic [USEDW_W-1:0] usedw,
   output logic               busy,
   output logic               done,
   output logic [7:0]         frm_cnt
`ifdef SPI_PATTERN_ERR_INJ_EN
   ,
   input  logic               err_inj
`endif
);

   localparam logic [7:0] LAST_IDX = 8'(PATTERN_LEN - 1);
   // Gap counter counts down to zero, so it is loaded with one less than the gap.
   localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   pgen_state_t     state_q,     state_d;
   logic [7:0]      idx_q,       idx_d;
   logic [7:0]      gap_cnt_q,   gap_cnt_d;
   logic [7:0]      frm_cnt_q,   frm_cnt_d;
   logic [7:0]      frm_tgt_q,   frm_tgt_d;
   logic            stop_pend_q, stop_pend_d;
   logic [DATA-1:0] wdata_q,     wdata_d;
   logic            busy_q,      busy_d;
   logic            done_q,      done_d;

   logic stop_seen;
   logic tgt_hit;
   logic last_write;
   logic wdata_upd;

   // Fill level is informational only; reduce it so it is visibly consumed.
   logic unused_usedw;
   assign unused_usedw = ^usedw;

   // Write strobe follows full combinationally so a stall costs no extra cycle.
   assign wr         = (state_q == WRITE) && !full;
   assign last_write = wr && (idx_q == LAST_IDX);
   assign stop_seen  = stop_pend_q | stop;
   // Compare against the count before this frame's increment lands.
   assign tgt_hit    = (frm_tgt_q != 8'd0) && ((frm_cnt_q + 8'd1) == frm_tgt_q);

`ifdef SPI_PATTERN_ERR_INJ_EN
   localparam logic [7:0] ERR_IDX = 8'(PATTERN_LEN / 2);
   logic err_pend_q, err_pend_d;
   logic flip_q,     flip_d;
`endif

   always_comb begin
      // NOTE: every _d gets a hold default first so no path infers a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      gap_cnt_d   = gap_cnt_q;
      frm_cnt_d   = frm_cnt_q;
      frm_tgt_d   = frm_tgt_q;
      stop_pend_d = stop_pend_q;
      wdata_d     = wdata_q;

      unique case (state_q)
         IDLE: begin
            // stop is ignored here; start wins when both arrive together.
            stop_pend_d = 1'b0;
            if (start) begin
               state_d   = WRITE;
               frm_tgt_d = frames;
               frm_cnt_d = 8'd0;
               idx_d     = 8'd0;
            end
         end

         WRITE: begin
            stop_pend_d = stop_seen;
            if (wr) begin
               idx_d = idx_q + 8'd1;
            end
            if (last_write) begin
               idx_d     = 8'd0;
               frm_cnt_d = frm_cnt_q + 8'd1;
               if (stop_seen || tgt_hit) begin
                  state_d = DONE;
               end else if (GAP_CYCLES == 0) begin
                  state_d = WRITE;
               end else begin
                  state_d   = GAP;
                  gap_cnt_d = GAP_LOAD;
               end
            end
         end

         GAP: begin
            stop_pend_d = stop_seen;
            if (gap_cnt_q == 8'd0) begin
               state_d = stop_seen ? DONE : WRITE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // A stop is consumed by the transition it causes.
      if (state_d == DONE) begin
         stop_pend_d = 1'b0;
      end

      busy_d = (state_d == WRITE) || (state_d == GAP);
      done_d = (state_d == DONE);

      // wdata is registered: refresh it only when idx moves or WRITE is entered,
      // so it stays stable across a full stall.
      wdata_upd = (state_d == WRITE) && ((state_q != WRITE) || wr);

`ifdef SPI_PATTERN_ERR_INJ_EN
      err_pend_d = err_pend_q | err_inj;
      if (wr && flip_q) begin
         err_pend_d = 1'b0;
      end
      flip_d = flip_q;
      if (wdata_upd) begin
         flip_d  = err_pend_d && (idx_d == ERR_IDX);
         wdata_d = (DATA'(FIRST_CHAR) + DATA'(idx_d)) ^ DATA'(flip_d);
      end
`else
      if (wdata_upd) begin
         wdata_d = DATA'(FIRST_CHAR) + DATA'(idx_d);
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= 8'd0;
         gap_cnt_q   <= 8'd0;
         frm_cnt_q   <= 8'd0;
         frm_tgt_q   <= 8'd0;
         stop_pend_q <= 1'b0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SPI_PATTERN_ERR_INJ_EN
         err_pend_q  <= 1'b0;
         flip_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_cnt_q   <= gap_cnt_d;
         frm_cnt_q   <= frm_cnt_d;
         frm_tgt_q   <= frm_tgt_d;
         stop_pend_q <= stop_pend_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SPI_PATTERN_ERR_INJ_EN
         err_pend_q  <= err_pend_d;
         flip_q      <= flip_d;
`endif
      end
   end

   assign wdata   = wdata_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign frm_cnt = frm_cnt_q;

endmodule : spi_pattern_gen

// File: tb/tb_spi_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_pattern_gen
// Scoreboard bench for spi_pattern_gen (default parameters). The stimulus
// thread computes the expected byte stream and done events from the frame
// rules and queues them; a monitor on the falling edge pops and compares
// whenever wr or done is presented.
// ---------------------------------------------------------------------------
module tb_spi_pattern_gen;

   localparam int         LEN   = 9;
   localparam int         GAP   = 2;
   localparam logic [7:0] FIRST = 8'h31;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       start  = 1'b0;
   logic       stop   = 1'b0;
   logic [7:0] frames = 8'd0;
   logic       full   = 1'b0;
   logic [3:0] usedw  = 4'd0;
   logic [7:0] wdata;
   logic       wr;
   logic       busy;
   logic       done;
   logic [7:0] frm_cnt;
`ifdef SPI_PATTERN_ERR_INJ_EN
   logic       err_inj = 1'b0;
`endif

   spi_pattern_gen dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .frames  (frames),
      .wdata   (wdata),
      .wr      (wr),
      .full    (full),
      .usedw   (usedw),
      .busy    (busy),
      .done    (done),
      .frm_cnt (frm_cnt)
`ifdef SPI_PATTERN_ERR_INJ_EN
      ,
      .err_inj (err_inj)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         idle;   // required idle cycles before this byte, -1 = don't care
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] done_q[$];

   int  n_checks  = 0;
   int  n_fail    = 0;
   int  wr_seen   = 0;
   int  done_seen = 0;
   int  idle_cnt  = 0;
   bit  full_rand = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compare every presented write and done pulse against the queues.
   initial begin
      exp_t e;
      logic [7:0] c;
      forever begin
         @(negedge clk);
         if (rst && wr) begin
            if (exp_q.size() == 0) begin
               check("spurious_wr", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("wdata", wdata, e.data);
               if (e.idle >= 0) check("idle_before_byte", idle_cnt, e.idle);
            end
            idle_cnt = 0;
            wr_seen++;
         end else begin
            idle_cnt++;
         end
         if (rst && done) begin
            if (done_q.size() == 0) begin
               check("spurious_done", done_q.size(), 1);
            end else begin
               c = done_q.pop_front();
               check("done_frm_cnt", frm_cnt, c);
               check("done_busy_low", busy, 0);
            end
            done_seen++;
         end
      end
   end

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (full_rand) full = ($urandom_range(0, 2) == 0);
      usedw = 4'($urandom);
   endtask

   // Reference stream: n whole frames of FIRST..FIRST+LEN-1.
   task automatic push_frames(input int n, input bit gaps);
      exp_t e;
      for (int f = 0; f < n; f++) begin
         for (int i = 0; i < LEN; i++) begin
            e.data = 8'(int'(FIRST) + i);
            if (!gaps)       e.idle = -1;
            else if (i != 0) e.idle = 0;
            else             e.idle = (f == 0) ? -1 : GAP;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_done(input int n);
      done_q.push_back(8'(n % 256));
   endtask

   task automatic pulse_start(input logic [7:0] f, input bit with_stop);
      frames = f;
      start  = 1'b1;
      stop   = with_stop;
      cycle();
      start  = 1'b0;
      stop   = 1'b0;
   endtask

   task automatic wait_writes(input int k, input int base, input int budget);
      int n = 0;
      while ((wr_seen - base) < k && n < budget) begin
         cycle();
         n++;
      end
      check("writes_reached", wr_seen - base, k);
   endtask

   task automatic wait_done(input int budget);
      int base = done_seen;
      int n    = 0;
      while (done_seen == base && n < budget) begin
         cycle();
         n++;
      end
      check("done_seen", done_seen - base, 1);
      cycle();
      cycle();
      check("exp_q_drained", exp_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      exp_q.delete();
      done_q.delete();
   endtask

   initial begin
      int base;
      int f;
      int k;
      int n;
      bit use_stop;

      // Reset state
      #2;
      check("rst_wr", wr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frm_cnt", frm_cnt, 0);
      cycle();
      cycle();
      rst = 1'b1;
      cycle();

      // Single frame: latency 1, nine back-to-back bytes, done with frm_cnt=1
      push_frames(1, 1'b1);
      push_done(1);
      pulse_start(8'd1, 1'b0);
      @(negedge clk);
      check("first_write_latency", wr, 1);
      check("busy_after_start", busy, 1);
      wait_done(100);
      check("idle_frm_cnt_1", frm_cnt, 1);

      // Three frames with two-cycle gaps; a start while busy is ignored
      push_frames(3, 1'b1);
      push_done(3);
      pulse_start(8'd3, 1'b0);
      repeat (12) cycle();
      frames = 8'd7;
      start  = 1'b1;
      cycle();
      start  = 1'b0;
      wait_done(200);
      check("idle_frm_cnt_3", frm_cnt, 3);

      // Backpressure: full for 4 cycles at idx=4 holds 8'h35
      push_frames(1, 1'b0);
      push_done(1);
      pulse_start(8'd1, 1'b0);
      base = wr_seen;
      wait_writes(4, base, 50);
      full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_wr_low", wr, 0);
         check("stall_wdata_held", wdata, 8'h35);
         @(posedge clk);
         #1;
      end
      full = 1'b0;
      wait_done(100);

      // Continuous, stop at idx=2 of frame 2: frame completes, 18 bytes
      push_frames(2, 1'b1);
      push_done(2);
      pulse_start(8'd0, 1'b0);
      base = wr_seen;
      wait_writes(11, base, 200);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      wait_done(200);
      check("stop_total_bytes", wr_seen - base, 18);

      // start and stop together in IDLE: stop dropped, both frames produced
      push_frames(2, 1'b1);
      push_done(2);
      pulse_start(8'd2, 1'b1);
      wait_done(200);

      // Asynchronous reset mid-frame, then a clean restart at 8'h31
      push_frames(1, 1'b0);
      pulse_start(8'd0, 1'b0);
      base = wr_seen;
      wait_writes(5, base, 50);
      #2;
      rst = 1'b0;
      #1;
      check("arst_wr", wr, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_frm_cnt", frm_cnt, 0);
      check("arst_wdata", wdata, 0);
      exp_q.delete();
      done_q.delete();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      push_frames(1, 1'b1);
      push_done(1);
      pulse_start(8'd1, 1'b0);
      wait_done(100);

      // Randomized runs with random backpressure and optional stop
      full_rand = 1'b1;
      for (int r = 0; r < 10; r++) begin
         f        = $urandom_range(0, 4);
         use_stop = (f == 0) || ($urandom_range(0, 1) == 1);
         if (use_stop) begin
            k = $urandom_range(1, (f == 0) ? 40 : f * LEN - 1);
            n = (k + LEN - 1) / LEN;   // the frame in flight when stop lands completes
         end else begin
            k = 0;
            n = f;
         end
         push_frames(n, 1'b0);
         push_done(n);
         pulse_start(8'(f), 1'b0);
         if (use_stop) begin
            base = wr_seen;
            wait_writes(k, base, 400);
            stop = 1'b1;
            cycle();
            stop = 1'b0;
         end
         wait_done(600);
      end
      full_rand = 1'b0;
      full      = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule : tb_spi_pattern_gen
